// File: rtl/alu_flag_pkg.sv
// -----------------------------------------------------------------------------
// alu_flag_pkg
// Shared definitions for the ALU flag unit: opcode encodings, the control FSM
// state type and the packed condition-flag record.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_flag_pkg;

    // Opcode encodings (5-bit; zero-extended to the opcode field width).
    localparam logic [4:0] OP_MOV = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00011;
    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [4:0] OP_OR  = 5'b00101;
    localparam logic [4:0] OP_AND = 5'b00110;
    localparam logic [4:0] OP_XOR = 5'b00111;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_MUL_BUSY = 2'b01,
        ST_HOLD     = 2'b10
    } state_e;

    // Condition flags loaded together with each result.
    typedef struct packed {
        logic zero;
        logic sign;
        logic carry;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/alu_flag_unit_mul.sv
// -----------------------------------------------------------------------------
// alu_flag_mul
// Iterative shift-add multiplier, one multiplier bit per clock, WIDTH steps.
// Only built when ALU_FLAG_MUL_EN is defined (instantiated by alu_flag_unit).
// Ports:
//   clk      - clock, rising edge
//   sys_rst  - synchronous active-high reset (aborts a running multiply)
//   start    - load operands and begin (ignored while busy)
//   a, b     - WIDTH-bit unsigned operands
//   done     - high during the cycle whose rising edge completes the last step
//   product  - 2*WIDTH-bit product; valid while done is high
// -----------------------------------------------------------------------------
module alu_flag_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] step_sum_s;

    // Partial-product step; the final step's sum is presented directly so the
    // caller can capture it on the same edge that would retire the multiply.
    always_comb begin
        step_sum_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
        product    = step_sum_s;
        done       = busy_q && (cnt_q == CW'(1));
    end

    // Next-state for the shift-add datapath and step counter.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start && !busy_q) begin
            acc_d    = {(2*WIDTH){1'b0}};
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = CW'(WIDTH);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = step_sum_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            busy_d   = (cnt_q != CW'(1));
        end else begin
            busy_d   = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_flag_unit.sv
// -----------------------------------------------------------------------------
// alu_flag_unit
// Single-issue ALU with registered result and condition flags and a
// valid/ready handshake on both sides.
// Build option: define ALU_FLAG_MUL_EN to include the iterative multiplier
// (opcode MUL, WIDTH+1 cycle latency); without it MUL is an illegal opcode.
// Ports:
//   clk, sys_rst             - clock and synchronous active-high reset
//   in_valid / in_ready      - operation handshake (ready only when idle)
//   oper_type                - opcode
//   src1, src2, imm          - operands; imm_mode=1 selects imm as operand 2
//   out_valid / out_ready    - result handshake
//   result                   - registered result
//   zero, sign, carry, overflow - registered flags, held until next load
//   illegal                  - one-cycle pulse for an undefined opcode
// -----------------------------------------------------------------------------
module alu_flag_unit
    import alu_flag_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   oper_type,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [WIDTH-1:0] imm,
    input  logic             imm_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             sign,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] op2_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH-1:0] sub_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_carry_s;
    logic             alu_ovf_s;
    logic             alu_legal_s;
    logic             is_mul_s;

`ifdef ALU_FLAG_MUL_EN
    logic               mul_start_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;
    logic               mul_hi_nz_s;

    alu_flag_mul #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .sys_rst (sys_rst),
        .start   (mul_start_s),
        .a       (src1),
        .b       (op2_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // Product overflows WIDTH bits when any upper half bit is set.
    assign mul_hi_nz_s = |mul_prod_s[2*WIDTH-1:WIDTH];
`endif

    // zero/sign always follow the value being loaded.
    function automatic flags_t pack_flags(input logic [WIDTH-1:0] r,
                                          input logic c, input logic v);
        flags_t f;
        f.zero     = (r == {WIDTH{1'b0}});
        f.sign     = r[WIDTH-1];
        f.carry    = c;
        f.overflow = v;
        return f;
    endfunction

    // Single-cycle datapath and opcode decode.
    always_comb begin
        op2_s       = imm_mode ? imm : src2;
        add_s       = {1'b0, src1} + {1'b0, op2_s};
        sub_s       = src1 - op2_s;
        alu_res_s   = {WIDTH{1'b0}};
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        alu_legal_s = 1'b0;
        is_mul_s    = 1'b0;
        case (oper_type)
            OPW'(OP_MOV): begin
                alu_res_s   = op2_s;
                alu_legal_s = 1'b1;
            end
            OPW'(OP_ADD): begin
                alu_res_s   = add_s[WIDTH-1:0];
                alu_carry_s = add_s[WIDTH];
                alu_ovf_s   = (src1[WIDTH-1] == op2_s[WIDTH-1]) &&
                              (add_s[WIDTH-1] != src1[WIDTH-1]);
                alu_legal_s = 1'b1;
            end
            OPW'(OP_SUB): begin
                alu_res_s   = sub_s;
                alu_carry_s = (src1 < op2_s);
                alu_ovf_s   = (src1[WIDTH-1] != op2_s[WIDTH-1]) &&
                              (sub_s[WIDTH-1] != src1[WIDTH-1]);
                alu_legal_s = 1'b1;
            end
            OPW'(OP_MUL): begin
`ifdef ALU_FLAG_MUL_EN
                is_mul_s    = 1'b1;
`else
                is_mul_s    = 1'b0;
`endif
            end
            OPW'(OP_OR): begin
                alu_res_s   = src1 | op2_s;
                alu_legal_s = 1'b1;
            end
            OPW'(OP_AND): begin
                alu_res_s   = src1 & op2_s;
                alu_legal_s = 1'b1;
            end
            OPW'(OP_XOR): begin
                alu_res_s   = src1 ^ op2_s;
                alu_legal_s = 1'b1;
            end
            default: begin
                alu_legal_s = 1'b0;
            end
        endcase
    end

    // Control FSM: result/flags change only when a result is loaded.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        illegal_d   = 1'b0;
`ifdef ALU_FLAG_MUL_EN
        mul_start_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (alu_legal_s) begin
                        result_d    = alu_res_s;
                        flags_d     = pack_flags(alu_res_s, alu_carry_s, alu_ovf_s);
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end else if (is_mul_s) begin
`ifdef ALU_FLAG_MUL_EN
                        mul_start_s = 1'b1;
                        state_d     = ST_MUL_BUSY;
`else
                        illegal_d   = 1'b1;
`endif
                    end else begin
                        illegal_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef ALU_FLAG_MUL_EN
            ST_MUL_BUSY: begin
                if (mul_done_s) begin
                    result_d    = mul_prod_s[WIDTH-1:0];
                    flags_d     = pack_flags(mul_prod_s[WIDTH-1:0], mul_hi_nz_s, mul_hi_nz_s);
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    state_d = ST_MUL_BUSY;
                end
            end
`endif
            ST_HOLD: begin
                // Handshake completes here; a new op is only taken from IDLE.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            result_q    <= {WIDTH{1'b0}};
            flags_q     <= '{zero: 1'b0, sign: 1'b0, carry: 1'b0, overflow: 1'b0};
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = flags_q.zero;
    assign sign      = flags_q.sign;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign illegal   = illegal_q;

endmodule

// File: doc/alu_flag_unit.md
ALU_FLAG_UNIT -- requirements
Module: alu_flag_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits (legal 8..64).
REQ-002 The block SHALL have parameter OPW, default 5, meaning opcode field width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port sys_rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports in_valid input 1, in_ready output 1, with operation accepted when both are high at a clk edge.
REQ-006 The block SHALL have ports oper_type input OPW, src1 input WIDTH, src2 input WIDTH, imm input WIDTH, imm_mode input 1 (1 = second operand is imm).
REQ-007 The block SHALL have ports out_valid output 1, out_ready input 1, result output WIDTH.
REQ-008 The block SHALL have outputs zero, sign, carry, overflow (1 bit each, registered condition flags) and illegal (1-bit pulse).

Function
REQ-009 Opcodes SHALL be: 00001 MOV (op2), 00010 ADD, 00011 SUB (src1-op2), 00100 MUL (low WIDTH bits), 00101 OR, 00110 AND, 00111 XOR; op2 = imm_mode ? imm : src2.
REQ-010 FSM states SHALL be IDLE, MUL_BUSY, HOLD; in_ready = 1 only in IDLE.
REQ-011 Non-MUL ops accepted in IDLE SHALL load result and flags at the accepting edge; out_valid rises that edge (latency 1) and the FSM enters HOLD.
REQ-012 MUL SHALL run shift-add, one bit per cycle, for exactly WIDTH cycles in MUL_BUSY; result and flags load at the edge entering HOLD (latency WIDTH+1).
REQ-013 In HOLD, result/flags/out_valid SHALL stay stable until out_valid && out_ready, then out_valid clears and the FSM returns to IDLE (no same-cycle accept).
REQ-014 zero SHALL = (result == 0); sign SHALL = result[WIDTH-1] for every op.
REQ-015 ADD: carry = bit WIDTH of the unsigned sum; overflow = operands same sign and result sign differs.
REQ-016 SUB: carry = borrow (src1 < op2 unsigned); overflow = operands differ in sign and result sign differs from src1.
REQ-017 MUL: carry = overflow = 1 iff the upper WIDTH bits of the 2*WIDTH product are nonzero.
REQ-018 MOV, OR, AND, XOR SHALL clear carry and overflow.
REQ-019 Undefined opcodes SHALL pulse illegal for one cycle at acceptance, produce no out_valid, leave result and flags unchanged, and stay in IDLE.
REQ-020 Flags SHALL hold their last value until the next result load, including while idle.

Reset
REQ-021 On sys_rst high at a clk edge: state IDLE, result 0, all flags 0, out_valid 0, illegal 0; in_ready 1 in the following cycle.
REQ-022 Reset during MUL_BUSY or HOLD SHALL abort the operation with no out_valid for it.

Configuration
REQ-023 Macro ALU_FLAG_MUL_EN defined: MUL and MUL_BUSY implemented per REQ-012/017.
REQ-024 Macro ALU_FLAG_MUL_EN undefined: no multiplier logic; opcode 00100 treated as illegal per REQ-019.

Structure
REQ-025 A shared package alu_flag_pkg SHALL hold the opcode localparams, FSM state enum, and a flag struct {zero, sign, carry, overflow}.
REQ-026 The iterative multiplier SHALL be a sub-module alu_flag_mul (start, done, operands, 2*WIDTH product), instantiated only under ALU_FLAG_MUL_EN.

Verification (WIDTH=16)
REQ-027 ADD imm_mode=1, src1=2, imm=4 -> result 6, all flags 0, out_valid one cycle after accept.
REQ-028 ADD src1=0x8000, src2=0x8002 -> result 0x0002, carry=1, overflow=1, zero=0, sign=0; ADD 0+0 -> zero=1.
REQ-029 SUB src1=3, src2=5 -> result 0xFFFE, carry=1, sign=1, overflow=0; AND 7&56 -> 0, zero=1, carry=0.
REQ-030 MUL 300*300 (MUL_EN) -> out_valid 17 cycles after accept, result 0x5F90, carry=overflow=1; without MUL_EN -> illegal pulse, no out_valid.
REQ-031 Hold out_ready=0 for 5 cycles after ADD result -> result/flags stable, in_ready=0; new in_valid ignored until handshake.
REQ-032 Assert sys_rst at MUL cycle 8 -> next cycle out_valid=0, flags 0, in_ready=1; next MUL 2*3 -> result 6.
